// File: rtl/pixel_scanner_if.sv
// pixel_scanner_if: scan control inputs and anode/select/frame outputs of the display scanner
interface pixel_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  localparam int SEL_W = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [BRIGHT_W-1:0]   brightness;
  logic [NUM_DIGITS-1:0] anodes;
  logic [SEL_W-1:0]      sel;
  logic                  frame_start;
  modport master (output enable, digit_mask, brightness, input anodes, sel, frame_start);
  modport slave  (input enable, digit_mask, brightness, output anodes, sel, frame_start);
endinterface

// File: rtl/pixel_scanner.sv
// pixel_scanner: time-multiplexed 7-segment digit scan with blank guard, mask and PWM brightness
module pixel_scanner #(
  parameter int NUM_DIGITS       = 8,
  parameter int TICK_DIV         = 100000,
  parameter int BLANK_CYCLES     = 2,
  parameter int BRIGHT_W         = 4,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input logic             clk,
  input logic             reset,
  pixel_scanner_if.slave  bus
);
  localparam int SEL_W = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = TICK_DIV > 2 ? $clog2(TICK_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] OFF = ANODE_ACTIVE_LOW != 0 ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d, act;
  logic                  frame_start_q, frame_start_d;
  logic                  slot_end;

  // Next slot position, phase and registered outputs; outputs are computed for the next cycle so they leave flops
  always_comb begin
    state_d = S_IDLE;
    cnt_d = '0;
    sel_d = '0;
    act = '0;
    slot_end = cnt_q == CNT_W'(TICK_DIV - 1);
    if (bus.enable && state_q != S_IDLE) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      sel_d = !slot_end ? sel_q : sel_q == SEL_W'(NUM_DIGITS - 1) ? '0 : sel_q + 1'b1;
    end
    if (bus.enable) state_d = cnt_d < CNT_W'(BLANK_CYCLES) ? S_BLANK : S_ON;
    frame_start_d = bus.enable && cnt_d == '0 && sel_d == '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      act[k] = state_d == S_ON && sel_d == SEL_W'(k) && bus.digit_mask[k] &&
               cnt_d[BRIGHT_W-1:0] <= bus.brightness;
    anodes_d = ANODE_ACTIVE_LOW != 0 ? ~act : act;
  end

  // State and output registers, cleared asynchronously to idle with all anodes dark
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      anodes_q      <= OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      anodes_q      <= anodes_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.anodes      = anodes_q;
  assign bus.sel         = sel_q;
  assign bus.frame_start = frame_start_q;
endmodule
